// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and tick-aligned launch controller ahead of an 8N1 transmitter
//
// Purpose:
//   Buffers host bytes in a circular register array and hands the head byte to
//   the serial transmitter. A launch is only ever issued on a uart_tick cycle,
//   which lets the next frame start exactly at the end of the stop bit.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   uart_tick    in   one-cycle baud tick shared with the transmitter
//   wr_en        in   push wr_data (dropped when full)
//   wr_data      in   byte to enqueue
//   enable       in   1 = launch queued bytes, 0 = hold queue
//   flush        in   synchronous queue clear
//   ovf_clear    in   clear sticky overflow
//   tx_ready     in   transmitter idle or in stop bit
//   tx_start     out  launch pulse to transmitter
//   tx_data      out  head byte (first-word-fall-through)
//   full         out  count == depth
//   almost_full  out  count >= AFULL_LEVEL
//   empty        out  count == 0
//   count        out  entries held
//   overflow     out  sticky: a push was dropped

module uart_tx_fifo #(
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  uart_tick,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  ovf_clear,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [7:0]          mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                push;
  logic                pop;
  logic                drop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  assign count       = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign almost_full = (count >= AFULL_CNT);

  assign tx_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Launch is combinational on uart_tick so the transmitter can register the
  // byte on the very tick that ends the previous stop bit.
  assign tx_start = uart_tick & tx_ready & ~empty & enable & ~flush;

  // full/empty come from pre-edge state, so a push while full is dropped even
  // if a pop happens in the same cycle.
  assign push = wr_en & ~full & ~flush;
  assign pop  = tx_start;
  assign drop = wr_en & full & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A drop in the same cycle as ovf_clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule
